spi_pico_deframer: RTL

//  Front end of the SPI peripheral. Deserialises serial_in (MSB first) into frames of
//  one address byte followed by N data bytes. Address auto-increments after each data byte.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/pico_shift8.sv | 29 ++
 rtl/spi_pico_deframer.sv | 80 ++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types, register map constants and address helpers for the SPI PICO deframer.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {S_ADDR, S_DATA} pico_state_t;

  localparam logic [7:0] ADDR_TRIG_MASK  = 8'd1;
  localparam logic [7:0] ADDR_INSTR      = 8'd2;
  localparam logic [7:0] ADDR_MODE       = 8'd3;
  localparam logic [7:0] ADDR_DISC_POL   = 8'd60;
  localparam logic [7:0] ADDR_VCO        = 8'd61;
  localparam logic [7:0] ADDR_PLL_DIV    = 8'd62;
  localparam logic [7:0] ADDR_PLL_LOCKED = 8'd63;
  localparam logic [7:0] ADDR_SLOW       = 8'd64;
  localparam logic [7:0] ADDR_TRIG_DLY   = 8'd65;

  localparam logic [7:0] MAX_ADDR = ADDR_TRIG_DLY;
  localparam logic [7:0] RO_ADDR  = ADDR_PLL_LOCKED;
  localparam logic [7:0] ADDR_SAT = MAX_ADDR + 8'd1;

  // pll_locked is read-only and address 0 is unmapped
  function automatic logic addr_writable(input logic [7:0] addr);
    return (addr != 8'd0) && (addr <= MAX_ADDR) && (addr != RO_ADDR);
  endfunction

  function automatic logic [7:0] next_addr(input logic [7:0] addr);
    return (addr >= ADDR_SAT) ? ADDR_SAT : addr + 8'd1;
  endfunction

endpackage

// File: rtl/pico_shift8.sv
// Serial-to-parallel byte assembler: MSB-first shift register with a free-running bit counter.
module pico_shift8
  import spi_pkg::*;
(
  input  logic              sclk,
  input  logic              rstn,
  input  logic              serial_in,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_done
);

  // Only the previous 7 bits are stored; the 8th comes straight from serial_in.
  logic [BYTE_W-2:0] sh_reg;
  logic [2:0]        bit_cnt_reg;

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      sh_reg      <= '0;
      bit_cnt_reg <= 3'd0;
    end else begin
      sh_reg      <= {sh_reg[BYTE_W-3:0], serial_in};
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
    end
  end

  assign byte_data = {sh_reg, serial_in};
  assign byte_done = (bit_cnt_reg == 3'd7);

endmodule

// File: rtl/spi_pico_deframer.sv
// SPI PICO frame parser: address byte then auto-incrementing data bytes with write strobes.
// Optional R/W flag in address bit7 enabled by defining SPI_RW_BIT_EN.
module spi_pico_deframer
  import spi_pkg::*;
(
  input  logic       sclk,
  input  logic       rstn,
  input  logic       serial_in,
  output logic [7:0] write_data,
  output logic [7:0] mux_control_signal,
  output logic       addr_valid,
  output logic       msg_flag,
  output logic       wr_en,
  output logic       rd_frame
);

  logic [7:0]  byte_data;
  logic        byte_done;
  pico_state_t state_reg;

  pico_shift8 u_shift (
    .sclk      (sclk),
    .rstn      (rstn),
    .serial_in (serial_in),
    .byte_data (byte_data),
    .byte_done (byte_done)
  );

`ifdef SPI_RW_BIT_EN
  logic rd_frame_reg;
  assign rd_frame = rd_frame_reg;
`else
  assign rd_frame = 1'b0;
`endif

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_reg          <= S_ADDR;
      write_data         <= 8'd0;
      mux_control_signal <= 8'd0;
      addr_valid         <= 1'b0;
      msg_flag           <= 1'b0;
      wr_en              <= 1'b0;
`ifdef SPI_RW_BIT_EN
      rd_frame_reg       <= 1'b0;
`endif
    end else begin
      msg_flag <= 1'b0;
      wr_en    <= 1'b0;
      // Advance only after the strobe cycle so the downstream mux sees a stable address.
      if (msg_flag)
        mux_control_signal <= next_addr(mux_control_signal);
      if (byte_done) begin
        case (state_reg)
          S_ADDR: begin
`ifdef SPI_RW_BIT_EN
            mux_control_signal <= {1'b0, byte_data[6:0]};
            rd_frame_reg       <= byte_data[7];
`else
            mux_control_signal <= byte_data;
`endif
            addr_valid <= 1'b1;
            state_reg  <= S_DATA;
          end
          S_DATA: begin
            write_data <= byte_data;
            msg_flag   <= 1'b1;
`ifdef SPI_RW_BIT_EN
            wr_en      <= addr_writable(mux_control_signal) && !rd_frame_reg;
`else
            wr_en      <= addr_writable(mux_control_signal);
`endif
          end
          default: state_reg <= S_ADDR;
        endcase
      end
    end
  end

endmodule
